// File: rtl/fsm_door_lock_pkg.sv
// Shared types for the push-button combination lock.
package fsm_door_pkg;

  // Lock FSM states; 4-bit encoding leaves room for future states.
  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFirstOk  = 4'd1,
    StFirstBad = 4'd2,
    StOpen     = 4'd3,
    StWrong    = 4'd4,
    StAlarm    = 4'd5
  } state_t;

  // Button symbol; zero means no button held.
  typedef logic [1:0] sym_t;

  localparam sym_t SYM_NONE = 2'd0;

endpackage

// File: rtl/fsm_door_lock_press_detect.sv
// Button press detector: a press is the idle-to-nonzero transition of the button bus.
// A slide between two non-zero symbols and a held button produce no extra press.
module press_detect
  import fsm_door_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic [1:0] bn,
  output logic       press,
  output logic [1:0] symbol
);

  sym_t bn_prev_q;

  // Remember last sampled button value for edge detection.
  always_ff @(posedge clock) begin
    if (clear) begin
      bn_prev_q <= SYM_NONE;
    end else begin
      bn_prev_q <= bn;
    end
  end

  // Press only when leaving the all-released state.
  always_comb begin
    press  = (bn != SYM_NONE) && (bn_prev_q == SYM_NONE);
    symbol = bn;
  end

endmodule

// File: rtl/fsm_door_lock.sv
// Two-symbol combination lock with wrong-attempt counter and alarm lockout.
// Optional feature macro: AUTO_RELOCK_EN (OPEN times out after RELOCK_CYCLES clocks).
module fsm_door_lock
  import fsm_door_pkg::*;
#(
  parameter logic [1:0]  CODE0         = 2'b11,
  parameter logic [1:0]  CODE1         = 2'b11,
  parameter int unsigned MAX_WRONG     = 3,
  parameter int unsigned RELOCK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [2:1] bn,
  output logic       LED_right,
  output logic       LED_wrong,
  output logic       Buzzer
);

  localparam logic [2:0] MaxWrong = 3'(MAX_WRONG);
  localparam logic [1:0] WrongSat = 2'(MAX_WRONG);

  logic       press;
  logic [1:0] symbol;
  logic       fail;

  state_t     state_q, state_d;
  logic [1:0] wrong_cnt_q, wrong_cnt_d;
  logic       led_right_q, led_wrong_q, buzzer_q;

  press_detect u_press_detect (
    .clock  (clock),
    .clear  (clear),
    .bn     (bn),
    .press  (press),
    .symbol (symbol)
  );

`ifdef AUTO_RELOCK_EN
  localparam int unsigned RelockW = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
  localparam logic [RelockW-1:0] RelockLoad = RelockW'(RELOCK_CYCLES - 1);

  logic [RelockW-1:0] relock_q, relock_d;

  // Relock timer: load on entry to OPEN, count down while OPEN.
  always_comb begin
    relock_d = relock_q;
    if ((state_d == StOpen) && (state_q != StOpen)) begin
      relock_d = RelockLoad;
    end else if ((state_q == StOpen) && (relock_q != '0)) begin
      relock_d = relock_q - 1'b1;
    end
  end

  // Relock timer register.
  always_ff @(posedge clock) begin
    if (clear) begin
      relock_q <= '0;
    end else begin
      relock_q <= relock_d;
    end
  end
`else
  // Relock hold time is meaningless without the timer.
  logic unused_relock;
  assign unused_relock = ^RELOCK_CYCLES;
`endif

  // Next-state and wrong-attempt bookkeeping.
  always_comb begin
    state_d     = state_q;
    wrong_cnt_d = wrong_cnt_q;
    fail        = 1'b0;
    unique case (state_q)
      StIdle, StOpen, StWrong: begin
        if (press) begin
          state_d = (symbol == CODE0) ? StFirstOk : StFirstBad;
        end
`ifdef AUTO_RELOCK_EN
        else if ((state_q == StOpen) && (relock_q == '0)) begin
          state_d = StIdle;
        end
`endif
      end
      StFirstOk: begin
        if (press) begin
          if (symbol == CODE1) begin
            state_d = StOpen;
          end else begin
            fail = 1'b1;
          end
        end
      end
      StFirstBad: begin
        if (press) begin
          fail = 1'b1;
        end
      end
      StAlarm: begin
        state_d = StAlarm;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Counter saturates at MAX_WRONG when the lockout is reached.
    if (fail) begin
      if (({1'b0, wrong_cnt_q} + 3'd1) >= MaxWrong) begin
        state_d     = StAlarm;
        wrong_cnt_d = WrongSat;
      end else begin
        state_d     = StWrong;
        wrong_cnt_d = wrong_cnt_q + 2'd1;
      end
    end

    if (state_d == StOpen) begin
      wrong_cnt_d = '0;
    end
  end

  // State, counter and Moore output registers; outputs follow the next state.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= StIdle;
      wrong_cnt_q <= '0;
      led_right_q <= 1'b0;
      led_wrong_q <= 1'b0;
      buzzer_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrong_cnt_q <= wrong_cnt_d;
      led_right_q <= (state_d == StOpen);
      led_wrong_q <= (state_d == StWrong) || (state_d == StAlarm);
      buzzer_q    <= (state_d == StAlarm);
    end
  end

  assign LED_right = led_right_q;
  assign LED_wrong = led_wrong_q;
  assign Buzzer    = buzzer_q;

endmodule

// File: tb/tb_fsm_door_lock.sv
// Self-checking bench for fsm_door_lock: directed scenarios plus randomized
// button traffic against an entry-level reference model.
module tb_fsm_door_lock;

  localparam logic [1:0] CODE0         = 2'b11;
  localparam logic [1:0] CODE1         = 2'b11;
  localparam int         MAX_WRONG     = 3;
  localparam int         RELOCK_CYCLES = 16;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic [2:1] bn    = 2'd0;
  logic       LED_right, LED_wrong, Buzzer;

  int checks   = 0;
  int failures = 0;

  // Reference model: symbols entered in the current attempt and the visible results.
  logic [1:0] m_prev;
  logic [1:0] m_entry[$];
  bit         m_open, m_wrong_led, m_alarm;
  int         m_wrong;
`ifdef AUTO_RELOCK_EN
  int         m_timer;
`endif

  always #5 clock = ~clock;

  fsm_door_lock #(
    .CODE0         (CODE0),
    .CODE1         (CODE1),
    .MAX_WRONG     (MAX_WRONG),
    .RELOCK_CYCLES (RELOCK_CYCLES)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .bn        (bn),
    .LED_right (LED_right),
    .LED_wrong (LED_wrong),
    .Buzzer    (Buzzer)
  );

  function automatic void model_update(input logic [1:0] b, input logic c);
    bit press;
    if (c) begin
      m_prev = 2'd0;
      m_entry.delete();
      m_open = 0;
      m_wrong_led = 0;
      m_alarm = 0;
      m_wrong = 0;
      return;
    end
    press  = (b != 2'd0) && (m_prev == 2'd0);
    m_prev = b;
    if (m_alarm) return;
    if (press) begin
      if (m_entry.size() == 0) begin
        m_entry.push_back(b);
        m_open = 0;
        m_wrong_led = 0;
      end else begin
        if (m_entry[0] == CODE0 && b == CODE1) begin
          m_open  = 1;
          m_wrong = 0;
`ifdef AUTO_RELOCK_EN
          m_timer = RELOCK_CYCLES - 1;
`endif
        end else begin
          m_wrong++;
          m_wrong_led = 1;
          if (m_wrong >= MAX_WRONG) m_alarm = 1;
        end
        m_entry.delete();
      end
    end
`ifdef AUTO_RELOCK_EN
    else if (m_open) begin
      if (m_timer == 0) m_open = 0;
      else m_timer--;
    end
`endif
  endfunction

  // One clock: drive on the falling edge, advance the model at the rising edge, settle.
  task automatic step(input logic [1:0] b, input logic c);
    @(negedge clock);
    bn    = b;
    clear = c;
    @(posedge clock);
    model_update(b, c);
    #1;
  endtask

  task automatic attempt(input logic [1:0] s0, input logic [1:0] s1);
    step(2'd0, 1'b0);
    step(s0, 1'b0);
    step(2'd0, 1'b0);
    step(s1, 1'b0);
  endtask

  task automatic test_reset;
    step(2'd0, 1'b1);
    checks++;
    if ({LED_right, LED_wrong, Buzzer} !== 3'b000) begin
      failures++;
      $display("FAIL reset outputs=%b required=000", {LED_right, LED_wrong, Buzzer});
    end
    step(2'd3, 1'b1);
    step(2'd0, 1'b0);
    step(2'd3, 1'b0);
    checks++;
    if ({LED_right, LED_wrong, Buzzer} !== 3'b000) begin
      failures++;
      $display("FAIL clear_wins_press outputs=%b required=000", {LED_right, LED_wrong, Buzzer});
    end
  endtask

  task automatic test_correct;
    step(2'd0, 1'b1);
    step(2'd0, 1'b0);
    step(2'd3, 1'b0);
    step(2'd0, 1'b0);
    checks++;
    if (LED_right !== 1'b0) begin
      failures++;
      $display("FAIL correct_before_second LED_right=%b required=0", LED_right);
    end
    step(2'd3, 1'b0);
    checks++;
    if ({LED_right, LED_wrong, Buzzer} !== 3'b100) begin
      failures++;
      $display("FAIL correct_open outputs=%b required=100", {LED_right, LED_wrong, Buzzer});
    end
  endtask

  task automatic test_wrong_then_right;
    step(2'd0, 1'b1);
    attempt(2'd1, 2'd1);
    checks++;
    if ({LED_right, LED_wrong, Buzzer} !== 3'b010) begin
      failures++;
      $display("FAIL wrong_once outputs=%b required=010", {LED_right, LED_wrong, Buzzer});
    end
    attempt(2'd3, 2'd3);
    checks++;
    if ({LED_right, LED_wrong, Buzzer} !== 3'b100) begin
      failures++;
      $display("FAIL right_after_wrong outputs=%b required=100", {LED_right, LED_wrong, Buzzer});
    end
    // Counter was cleared by OPEN: two more failures must not alarm.
    attempt(2'd1, 2'd2);
    attempt(2'd3, 2'd1);
    checks++;
    if ({LED_right, LED_wrong, Buzzer} !== 3'b010) begin
      failures++;
      $display("FAIL count_cleared_by_open outputs=%b required=010",
               {LED_right, LED_wrong, Buzzer});
    end
  endtask

  task automatic test_lockout;
    step(2'd0, 1'b1);
    for (int i = 1; i <= MAX_WRONG; i++) begin
      attempt(2'd1, 2'd1);
      checks++;
      if (Buzzer !== (i == MAX_WRONG) || LED_wrong !== 1'b1 || LED_right !== 1'b0) begin
        failures++;
        $display("FAIL lockout_attempt%0d outputs=%b required=01%0d", i,
                 {LED_right, LED_wrong, Buzzer}, (i == MAX_WRONG));
      end
    end
    attempt(2'd3, 2'd3);
    checks++;
    if ({LED_right, LED_wrong, Buzzer} !== 3'b011) begin
      failures++;
      $display("FAIL alarm_ignores_code outputs=%b required=011", {LED_right, LED_wrong, Buzzer});
    end
    step(2'd0, 1'b1);
    checks++;
    if ({LED_right, LED_wrong, Buzzer} !== 3'b000) begin
      failures++;
      $display("FAIL alarm_clear outputs=%b required=000", {LED_right, LED_wrong, Buzzer});
    end
  endtask

  task automatic test_hold_slide;
    step(2'd0, 1'b1);
    step(2'd0, 1'b0);
    step(2'd3, 1'b0);
    step(2'd3, 1'b0);
    step(2'd3, 1'b0);
    step(2'd0, 1'b0);
    step(2'd3, 1'b0);
    checks++;
    if ({LED_right, LED_wrong, Buzzer} !== 3'b100) begin
      failures++;
      $display("FAIL hold_is_one_press outputs=%b required=100", {LED_right, LED_wrong, Buzzer});
    end
    step(2'd0, 1'b1);
    step(2'd0, 1'b0);
    step(2'd3, 1'b0);
    step(2'd1, 1'b0);
    checks++;
    if ({LED_right, LED_wrong, Buzzer} !== 3'b000) begin
      failures++;
      $display("FAIL slide_no_press outputs=%b required=000", {LED_right, LED_wrong, Buzzer});
    end
    step(2'd0, 1'b0);
    step(2'd3, 1'b0);
    checks++;
    if ({LED_right, LED_wrong, Buzzer} !== 3'b100) begin
      failures++;
      $display("FAIL slide_then_second outputs=%b required=100", {LED_right, LED_wrong, Buzzer});
    end
  endtask

  task automatic test_mid_reset;
    step(2'd0, 1'b1);
    step(2'd0, 1'b0);
    step(2'd3, 1'b0);
    step(2'd0, 1'b1);
    step(2'd0, 1'b0);
    step(2'd3, 1'b0);
    checks++;
    if ({LED_right, LED_wrong, Buzzer} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_discard outputs=%b required=000", {LED_right, LED_wrong, Buzzer});
    end
    step(2'd0, 1'b0);
    step(2'd3, 1'b0);
    checks++;
    if (LED_right !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_then_open LED_right=%b required=1", LED_right);
    end
  endtask

  task automatic test_open_hold;
    int drop_at;
    step(2'd0, 1'b1);
    attempt(2'd3, 2'd3);
    drop_at = 0;
    for (int k = 1; k <= 2 * RELOCK_CYCLES; k++) begin
      step(2'd0, 1'b0);
      if (drop_at == 0 && LED_right !== 1'b1) drop_at = k;
    end
`ifdef AUTO_RELOCK_EN
    checks++;
    if (drop_at != RELOCK_CYCLES) begin
      failures++;
      $display("FAIL relock_time dropped_after=%0d required=%0d", drop_at, RELOCK_CYCLES);
    end
`else
    checks++;
    if (drop_at != 0) begin
      failures++;
      $display("FAIL open_holds dropped_after=%0d required=never", drop_at);
    end
`endif
  endtask

  task automatic test_random;
    int r;
    logic [1:0] b;
    logic c;
    step(2'd0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      b = (r < 5) ? 2'd0 : (r < 8) ? CODE0 : (r == 8) ? 2'd1 : 2'd2;
      c = ($urandom_range(0, 59) == 0);
      step(b, c);
      checks++;
      if ({LED_right, LED_wrong, Buzzer} !== {m_open, m_wrong_led, m_alarm}) begin
        failures++;
        $display("FAIL random_cycle%0d outputs=%b required=%b", i,
                 {LED_right, LED_wrong, Buzzer}, {m_open, m_wrong_led, m_alarm});
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong_then_right();
    test_lockout();
    test_hold_slide();
    test_mid_reset();
    test_open_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
